tl_rom_arbiter: RTL
===================

Name: tl_rom_arbiter

Overview:
- Two-requester TileLink-UL arbiter in front of the single-ported read ROM (r_rom).
- Grants one master at a time with round-robin fairness.
- Captures the winning A-channel beat into a holding register and forwards it to the ROM.
- Routes the resulting D-channel beat back to the granted master only.
- Exactly one transaction is outstanding at any time; the ROM has no concurrency.

Parameters:
ADDR_WIDTH, 64, A-channel address width
DATA_WIDTH, 64, D-channel data width; mask width is DATA_WIDTH/8
SRC_WIDTH, 4, a_source width; forwarded unchanged

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
m0  tilelink.slave  bundle  requester 0: a_opcode/a_size/a_source/a_address/a_mask/a_valid in, a_ready out; d_opcode/d_size/d_data/d_valid out, d_ready in
m1  tilelink.slave  bundle  requester 1, same fields as m0
rom  tilelink.master  bundle  downstream ROM port, same fields with directions reversed

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Values held while rst_n is low:
  - state=IDLE, last_grant=1 (so m0 wins first), grant=0, holding register=0.
  - rom.a_valid=0, rom.d_ready=0.
  - m0/m1 a_ready=0 and d_valid=0.
- Reset asserted mid-transaction: the transaction is abandoned with no response to the master. Any ROM D beat arriving after release is ignored, because d_ready stays 0 in IDLE.
- State IDLE:
  - Selection: if exactly one mX.a_valid is high, select it. If both are high, select the master != last_grant. If neither, stay in IDLE.
  - Acceptance: a_ready of the selected master is high combinationally in the same cycle; the a_ready of the other master is 0.
  - On that edge: grant<=sel, holding register <= {opcode,size,source,address,mask} of sel, state->ACQ.
- State ACQ:
  - rom.a_valid=1 and rom.a_* = holding register, held stable until rom.a_ready.
  - On rom.a_valid && rom.a_ready: state->RESP.
  - m0/m1 a_ready=0.
- State RESP:
  - Routing: rom.d_ready = m[grant].d_ready; m[grant].d_valid = rom.d_valid; m[!grant].d_valid=0.
  - d_opcode/d_size/d_data are broadcast to both masters; they are meaningful only with d_valid.
  - On rom.d_valid && rom.d_ready: last_grant<=grant, state->IDLE.
- Latency (ROM a_ready high, ROM response one cycle after its A handshake, master d_ready high):
  - Request accepted in cycle 0.
  - rom.a_valid in cycle 1.
  - D beat at the master in cycle 2.
  - Next grant possible in cycle 3.
- Master obligations and protocol properties:
  - A master may drop a_valid any time after its a_ready handshake; the beat is already captured.
  - No combinational path from rom.d_valid to any a_ready.
  - Opcode is not checked; a non-Get opcode is forwarded verbatim.
  - A master holding a_valid while the other is being served keeps waiting; it is never accepted outside IDLE.
- Fairness: under continuous requests from both masters, grants strictly alternate m0,m1,m0,... No master waits longer than one other transaction.

Test Plan:
1. Reset, then m0 alone issues Get addr 64'hEFCD_AB89_6745_2301, size 3, mask 8'hFF. Required: m0.a_ready in the first cycle; rom.a_address matches the next cycle; m0 receives TL_ACCESS_ACK_DATA with the ROM data; m1.d_valid stays 0 throughout.
2. m0 and m1 both assert a_valid in the same cycle right after reset (m0 addr 64'h0123_4567_89AB_CDEF, m1 addr 64'h0). Required: m0 is served first, then m1; each gets only its own d_valid; rom.a_valid is never high during RESP.
3. Both masters request back-to-back for 6 transactions. Required: grant order m0,m1,m0,m1,m0,m1; rom.a_source equals the requester's a_source each time.
4. ROM stalls a_ready low for 5 cycles in ACQ. Required: rom.a_* stays stable throughout the stall and m1.a_ready stays 0 while m1 requests; the transaction completes normally once a_ready rises.
5. Granted master holds d_ready=0 for 3 cycles while rom.d_valid=1. Required: rom.d_ready=0 for those cycles, state stays RESP, and completion happens on the first cycle with d_ready=1.
6. rst_n pulsed low during RESP. Required: all valid/ready outputs drop to 0 immediately (asynchronously); after release the next m1 request is accepted with no stale D beat delivered.

Source files
------------

// File: rtl/tl_rom_arbiter.sv
`default_nettype none
// tl_rom_arbiter: round-robin arbiter giving two TileLink-UL masters
// one-at-a-time access to a single-ported read ROM.
module tl_rom_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int SRC_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // requester 0
   input  logic [2:0]              i_m0_a_opcode,
   input  logic [2:0]              i_m0_a_size,
   input  logic [SRC_WIDTH-1:0]    i_m0_a_source,
   input  logic [ADDR_WIDTH-1:0]   i_m0_a_address,
   input  logic [DATA_WIDTH/8-1:0] i_m0_a_mask,
   input  logic                    i_m0_a_valid,
   output logic                    o_m0_a_ready,
   output logic [2:0]              o_m0_d_opcode,
   output logic [2:0]              o_m0_d_size,
   output logic [DATA_WIDTH-1:0]   o_m0_d_data,
   output logic                    o_m0_d_valid,
   input  logic                    i_m0_d_ready,
   // requester 1
   input  logic [2:0]              i_m1_a_opcode,
   input  logic [2:0]              i_m1_a_size,
   input  logic [SRC_WIDTH-1:0]    i_m1_a_source,
   input  logic [ADDR_WIDTH-1:0]   i_m1_a_address,
   input  logic [DATA_WIDTH/8-1:0] i_m1_a_mask,
   input  logic                    i_m1_a_valid,
   output logic                    o_m1_a_ready,
   output logic [2:0]              o_m1_d_opcode,
   output logic [2:0]              o_m1_d_size,
   output logic [DATA_WIDTH-1:0]   o_m1_d_data,
   output logic                    o_m1_d_valid,
   input  logic                    i_m1_d_ready,
   // downstream ROM
   output logic [2:0]              o_rom_a_opcode,
   output logic [2:0]              o_rom_a_size,
   output logic [SRC_WIDTH-1:0]    o_rom_a_source,
   output logic [ADDR_WIDTH-1:0]   o_rom_a_address,
   output logic [DATA_WIDTH/8-1:0] o_rom_a_mask,
   output logic                    o_rom_a_valid,
   input  logic                    i_rom_a_ready,
   input  logic [2:0]              i_rom_d_opcode,
   input  logic [2:0]              i_rom_d_size,
   input  logic [DATA_WIDTH-1:0]   i_rom_d_data,
   input  logic                    i_rom_d_valid,
   output logic                    o_rom_d_ready
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   logic                    r_grant;
   logic                    r_last_grant;
   logic [2:0]              r_opcode;
   logic [2:0]              r_size;
   logic [SRC_WIDTH-1:0]    r_source;
   logic [ADDR_WIDTH-1:0]   r_address;
   logic [MASK_WIDTH-1:0]   r_mask;

   logic w_idle;
   logic w_resp;
   logic w_any;
   logic w_sel;
   logic w_accept;
   logic w_rom_d_ready;

   assign w_idle = (r_state == S_IDLE);
   assign w_resp = (r_state == S_RESP);
   assign w_any  = i_m0_a_valid | i_m1_a_valid;

   // On contention the master that was not served last wins.
   assign w_sel    = (i_m0_a_valid & i_m1_a_valid) ? ~r_last_grant : i_m1_a_valid;
   // rst_n gates acceptance so a_ready is low for the whole reset interval.
   assign w_accept = rst_n & w_idle & w_any;

   assign o_m0_a_ready = w_accept & ~w_sel;
   assign o_m1_a_ready = w_accept &  w_sel;

   assign o_rom_a_valid   = (r_state == S_ACQ);
   assign o_rom_a_opcode  = r_opcode;
   assign o_rom_a_size    = r_size;
   assign o_rom_a_source  = r_source;
   assign o_rom_a_address = r_address;
   assign o_rom_a_mask    = r_mask;

   assign w_rom_d_ready = w_resp & (r_grant ? i_m1_d_ready : i_m0_d_ready);
   assign o_rom_d_ready = w_rom_d_ready;

   assign o_m0_d_valid  = w_resp & ~r_grant & i_rom_d_valid;
   assign o_m1_d_valid  = w_resp &  r_grant & i_rom_d_valid;
   assign o_m0_d_opcode = i_rom_d_opcode;
   assign o_m0_d_size   = i_rom_d_size;
   assign o_m0_d_data   = i_rom_d_data;
   assign o_m1_d_opcode = i_rom_d_opcode;
   assign o_m1_d_size   = i_rom_d_size;
   assign o_m1_d_data   = i_rom_d_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_opcode     <= '0;
         r_size       <= '0;
         r_source     <= '0;
         r_address    <= '0;
         r_mask       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant   <= w_sel;
                  r_opcode  <= w_sel ? i_m1_a_opcode  : i_m0_a_opcode;
                  r_size    <= w_sel ? i_m1_a_size    : i_m0_a_size;
                  r_source  <= w_sel ? i_m1_a_source  : i_m0_a_source;
                  r_address <= w_sel ? i_m1_a_address : i_m0_a_address;
                  r_mask    <= w_sel ? i_m1_a_mask    : i_m0_a_mask;
                  r_state   <= S_ACQ;
               end
            end
            S_ACQ: begin
               if (i_rom_a_ready) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_rom_d_valid && w_rom_d_ready) begin
                  r_last_grant <= r_grant;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
